swap_sort_ctrl: RTL

SWAP_SORT_CTRL -- requirements
Module: swap_sort_ctrl

---
 rtl/swap_sort_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/swap_sort_ctrl.sv
// ============================================================================
// Module   : swap_sort_ctrl
// Purpose  : Sequences init/reverse/bubble-sort swap commands for an external
//            8-entry register file; reports busy, done and a swap count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module swap_sort_ctrl #(
    parameter int DATA_W = 4,
    parameter int NREG   = 8,
    parameter int IDX_W  = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [1:0]                     mode,
    input  logic                           preload,
    input  logic [NREG-1:0][DATA_W-1:0]    rf_r,
    output logic                           rf_init,
    output logic                           rf_swap,
    output logic [IDX_W-1:0]               rf_x,
    output logic [IDX_W-1:0]               rf_y,
    output logic                           busy,
    output logic                           done,
    output logic [4:0]                     swap_count
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_INIT = 3'd1;
    localparam logic [2:0] S_REV  = 3'd2;
    localparam logic [2:0] S_SORT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [1:0] MODE_NOP  = 2'b00;
    localparam logic [1:0] MODE_REV  = 2'b01;
    localparam logic [1:0] MODE_DESC = 2'b11;

    localparam logic [IDX_W-1:0] MAX_IDX   = IDX_W'(NREG - 1);
    localparam logic [IDX_W-1:0] REV_LAST  = IDX_W'(NREG / 2 - 1);
    localparam logic [IDX_W-1:0] LAST_J    = IDX_W'(NREG - 2);
    localparam logic [IDX_W-1:0] LAST_PASS = IDX_W'(NREG - 2);
    localparam logic [4:0]       SWAP_MAX  = 5'd31;

    logic [2:0]        state;
    logic [2:0]        state_next;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_p1;
    logic [IDX_W-1:0]  pass_cnt;
    logic              pass_swapped;
    logic [1:0]        mode_lat;
    logic              preload_lat;
    logic              cmp_swap;
    logic [DATA_W-1:0] val_a;
    logic [DATA_W-1:0] val_b;

    // Operation state reached once any preload cycle is out of the way.
    function automatic logic [2:0] op_state(input logic [1:0] m);
        logic [2:0] s;
        s = S_SORT;
        if (m == MODE_NOP) begin
            s = S_DONE;
        end else if (m == MODE_REV) begin
            s = S_REV;
        end
        return s;
    endfunction

    // Compare reads the live register file, so it always sees the swap
    // committed on the previous edge.
    always_comb begin
        idx_p1   = idx + IDX_W'(1);
        val_a    = rf_r[idx];
        val_b    = rf_r[idx_p1];
        cmp_swap = (mode_lat == MODE_DESC) ? (val_a < val_b) : (val_a > val_b);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = preload ? S_INIT : op_state(mode);
                end
            end
            S_INIT: state_next = op_state(mode_lat);
            S_REV: begin
                if (idx == REV_LAST) begin
                    state_next = S_DONE;
                end
            end
            S_SORT: begin
                if ((idx == LAST_J) &&
                    (!(pass_swapped || cmp_swap) || (pass_cnt == LAST_PASS))) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        rf_init = 1'b0;
        rf_swap = 1'b0;
        rf_x    = '0;
        rf_y    = '0;
        busy    = (state != S_IDLE);
        done    = (state == S_DONE);
        case (state)
            S_INIT: rf_init = preload_lat;
            S_REV: begin
                rf_swap = 1'b1;
                rf_x    = idx;
                rf_y    = MAX_IDX - idx;
            end
            S_SORT: begin
                rf_swap = cmp_swap;
                rf_x    = idx;
                rf_y    = idx_p1;
            end
            default: ;
        endcase
        // Register-file commands must never fire while reset is asserted.
        if (reset) begin
            rf_init = 1'b0;
            rf_swap = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx          <= '0;
            pass_cnt     <= '0;
            pass_swapped <= 1'b0;
            mode_lat     <= '0;
            preload_lat  <= 1'b0;
            swap_count   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx          <= '0;
                        pass_cnt     <= '0;
                        pass_swapped <= 1'b0;
                        mode_lat     <= mode;
                        preload_lat  <= preload;
                        swap_count   <= '0;
                    end
                end
                S_REV: begin
                    idx <= (idx == REV_LAST) ? '0 : idx_p1;
                end
                S_SORT: begin
                    if (idx == LAST_J) begin
                        idx          <= '0;
                        pass_cnt     <= pass_cnt + IDX_W'(1);
                        pass_swapped <= 1'b0;
                    end else begin
                        idx          <= idx_p1;
                        pass_swapped <= pass_swapped | cmp_swap;
                    end
                end
                default: idx <= '0;
            endcase
            if (rf_swap && (swap_count != SWAP_MAX)) begin
                swap_count <= swap_count + 5'd1;
            end
        end
    end

endmodule

`default_nettype wire
